// File: rtl/friscv_cache_invalidator_if.sv
// Request/erase bus of the friscv cache invalidation engine.
//
// Request side (cache control FSM):
//   flush_req    level request, held until flush_ack
//   flush_range  0 = full flush, 1 = range invalidate
//   flush_start  first byte address of the range
//   flush_end    last byte address of the range (inclusive)
//   flush_ways   way mask to erase
//   flush_ack    one-cycle completion pulse
//   flushing     high while erase writes are issued
//   init_done    sticky, post-reset erase complete
// Erase side (cache tag/data RAM write port):
//   cache_wren   per-way write enable
//   cache_wready RAM port accepts the write this cycle
//   cache_waddr  byte address of the erased line
//   cache_wdata  always zero
//
// slave modport: the invalidator. master modport: its environment.
interface friscv_cache_invalidator_if #(
    parameter int unsigned CACHE_BLOCK_W = 128,
    parameter int unsigned NB_WAYS       = 1,
    parameter int unsigned AXI_ADDR_W    = 32
);
    logic                     flush_req;
    logic                     flush_range;
    logic [AXI_ADDR_W-1:0]    flush_start;
    logic [AXI_ADDR_W-1:0]    flush_end;
    logic [NB_WAYS-1:0]       flush_ways;
    logic                     flush_ack;
    logic                     flushing;
    logic                     init_done;
    logic [NB_WAYS-1:0]       cache_wren;
    logic                     cache_wready;
    logic [AXI_ADDR_W-1:0]    cache_waddr;
    logic [CACHE_BLOCK_W-1:0] cache_wdata;

    modport slave (
        input  flush_req, flush_range, flush_start, flush_end, flush_ways,
        input  cache_wready,
        output flush_ack, flushing, init_done,
        output cache_wren, cache_waddr, cache_wdata
    );

    modport master (
        output flush_req, flush_range, flush_start, flush_end, flush_ways,
        output cache_wready,
        input  flush_ack, flushing, init_done,
        input  cache_wren, cache_waddr, cache_wdata
    );
endinterface

// File: rtl/friscv_cache_invalidator.sv
// Cache invalidation engine for the friscv instruction/data caches.
// Erases every line of every way after reset, then serves full flushes
// and address-range invalidations, one line index per accepted write,
// across a selectable set of ways, honouring RAM-port backpressure.
//
// Ports:
//   aclk     clock
//   aresetn  asynchronous active-low reset
//   srst     synchronous active-high reset, same effect as aresetn
//   bus      request + erase bus (slave modport of friscv_cache_invalidator_if)
module friscv_cache_invalidator #(
    parameter string       NAME          = "Cache-Invalidator",
    parameter int unsigned CACHE_BLOCK_W = 128,
    parameter int unsigned CACHE_DEPTH   = 512,
    parameter int unsigned NB_WAYS       = 1,
    parameter int unsigned AXI_ADDR_W    = 32
)(
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             srst,
    friscv_cache_invalidator_if.slave        bus
);

    localparam int unsigned OFFSET_W = $clog2(CACHE_BLOCK_W / 8);
    localparam int unsigned INDEX_W  = $clog2(CACHE_DEPTH);
    localparam int unsigned SPAN_W   = OFFSET_W + INDEX_W;
    localparam logic [INDEX_W:0] FULL_CNT = (INDEX_W + 1)'(CACHE_DEPTH);

    generate
        if (CACHE_BLOCK_W < 8 || (CACHE_BLOCK_W & (CACHE_BLOCK_W - 1)) != 0 ||
            CACHE_DEPTH < 2 || (CACHE_DEPTH & (CACHE_DEPTH - 1)) != 0 ||
            NB_WAYS < 1 || NB_WAYS > 8 || AXI_ADDR_W < SPAN_W) begin : g_bad_params
            $error("%s: illegal parameter set", NAME);
        end
    endgenerate

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        FLUSH,
        ACK
    } state_t;

    state_t                  state, state_n;
    logic [INDEX_W-1:0]      idx, idx_n;
    logic [INDEX_W:0]        remaining, remaining_n;
    logic [NB_WAYS-1:0]      way_mask, way_mask_n;
    logic [NB_WAYS-1:0]      wren, wren_n;
    logic                    armed, armed_n;
    logic                    done, done_n;
    logic                    ack, ack_n;
    logic                    busy, busy_n;
    logic [AXI_ADDR_W-1:0]   waddr, waddr_n;

    logic [INDEX_W-1:0]      rng_s;
    logic [INDEX_W-1:0]      rng_e;
    logic [INDEX_W-1:0]      first_idx;
    logic [INDEX_W-1:0]      idx_inc;
    logic [AXI_ADDR_W-1:0]   span;
    logic                    span_full;
    logic [INDEX_W:0]        rng_cnt;

    function automatic logic [AXI_ADDR_W-1:0] line_addr(input logic [INDEX_W-1:0] i);
        return AXI_ADDR_W'(i) << OFFSET_W;
    endfunction

    // Upper address bits are dropped on purpose: indexes alias.
    assign rng_s     = bus.flush_start[OFFSET_W +: INDEX_W];
    assign rng_e     = bus.flush_end[OFFSET_W +: INDEX_W];
    // A byte span covering the whole cache or more erases every line.
    assign span      = bus.flush_end - bus.flush_start;
    assign span_full = |(span >> SPAN_W);
    // Index difference wraps modulo CACHE_DEPTH, so e < s wraps through 0.
    assign rng_cnt   = span_full ? FULL_CNT
                                 : {1'b0, rng_e - rng_s} + (INDEX_W + 1)'(1);
    assign first_idx = bus.flush_range ? rng_s : '0;
    assign idx_inc   = idx + INDEX_W'(1);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        remaining_n = remaining;
        way_mask_n  = way_mask;
        wren_n      = wren;
        armed_n     = armed;
        done_n      = done;
        ack_n       = 1'b0;
        busy_n      = busy;
        waddr_n     = waddr;

        case (state)
            INIT, FLUSH: begin
                if (wren == '0) begin
                    // First INIT cycle after reset: start the sweep from the
                    // reset values of idx, remaining and way_mask.
                    wren_n  = way_mask;
                    busy_n  = 1'b1;
                    waddr_n = line_addr(idx);
                end else if (bus.cache_wready) begin
                    idx_n       = idx_inc;
                    remaining_n = remaining - (INDEX_W + 1)'(1);
                    waddr_n     = line_addr(idx_inc);
                    if (remaining == (INDEX_W + 1)'(1)) begin
                        wren_n = '0;
                        busy_n = 1'b0;
                        if (state == INIT) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ack_n   = 1'b1;
                            state_n = ACK;
                        end
                    end
                end
            end

            IDLE: begin
                if (!bus.flush_req) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    way_mask_n = bus.flush_ways;
                    if (bus.flush_ways == '0) begin
                        ack_n   = 1'b1;
                        state_n = ACK;
                    end else begin
                        idx_n       = first_idx;
                        remaining_n = bus.flush_range ? rng_cnt : FULL_CNT;
                        wren_n      = bus.flush_ways;
                        busy_n      = 1'b1;
                        waddr_n     = line_addr(first_idx);
                        state_n     = FLUSH;
                    end
                end
            end

            ACK: begin
                // A held request must be seen low again before re-arming.
                armed_n = 1'b0;
                state_n = IDLE;
            end

            default: begin
                state_n = INIT;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= INIT;
            idx       <= '0;
            remaining <= FULL_CNT;
            way_mask  <= '1;
            wren      <= '0;
            armed     <= 1'b0;
            done      <= 1'b0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            waddr     <= '0;
        end else if (srst) begin
            state     <= INIT;
            idx       <= '0;
            remaining <= FULL_CNT;
            way_mask  <= '1;
            wren      <= '0;
            armed     <= 1'b0;
            done      <= 1'b0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            waddr     <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            remaining <= remaining_n;
            way_mask  <= way_mask_n;
            wren      <= wren_n;
            armed     <= armed_n;
            done      <= done_n;
            ack       <= ack_n;
            busy      <= busy_n;
            waddr     <= waddr_n;
        end
    end

    assign bus.flush_ack   = ack;
    assign bus.flushing    = busy;
    assign bus.init_done   = done;
    assign bus.cache_wren  = wren;
    assign bus.cache_waddr = waddr;
    assign bus.cache_wdata = '0;

endmodule

// File: tb/tb_friscv_cache_invalidator.sv
// Scoreboard bench for friscv_cache_invalidator: requests push the expected
// erase writes and ack into a queue; a monitor pops and compares them.
module tb_friscv_cache_invalidator;

    localparam int unsigned BLK    = 128;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned WAYS   = 2;
    localparam int unsigned AW     = 32;
    localparam int unsigned LINE_B = BLK / 8;
    localparam int unsigned SPAN   = DEPTH * LINE_B;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic srst    = 1'b0;

    always #5 aclk = ~aclk;

    friscv_cache_invalidator_if #(
        .CACHE_BLOCK_W(BLK),
        .NB_WAYS(WAYS),
        .AXI_ADDR_W(AW)
    ) bus ();

    friscv_cache_invalidator #(
        .NAME("tb_inv"),
        .CACHE_BLOCK_W(BLK),
        .CACHE_DEPTH(DEPTH),
        .NB_WAYS(WAYS),
        .AXI_ADDR_W(AW)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .srst(srst),
        .bus(bus)
    );

    typedef struct {
        bit              is_ack;
        logic [AW-1:0]   addr;
        logic [WAYS-1:0] wren;
    } item_t;

    item_t sb[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    int    wmode  = 0;
    bit    hist[int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Ready pattern: 0 = always high, 1 = toggling, 2 = random (75% high).
    always @(posedge aclk) begin
        #1;
        case (wmode)
            0:       bus.cache_wready = 1'b1;
            1:       bus.cache_wready = ~bus.cache_wready;
            default: bus.cache_wready = ($urandom_range(3) != 0);
        endcase
        hist[cyc] = bus.cache_wready;
    end

    // Cycle after which the count-th accepted write (ready high, starting
    // at t0+1) completes; the completion indication follows one cycle later.
    function automatic int exp_done(input int t0, input int count);
        int c = t0;
        int k = 0;
        while (k < count) begin
            c++;
            if (!hist.exists(c)) return -1;
            if (hist[c]) k++;
        end
        return c + 1;
    endfunction

    // Monitor
    item_t           it;
    bit              prev_stall = 1'b0;
    logic [AW-1:0]   prev_addr;
    logic [WAYS-1:0] prev_wren;

    always @(negedge aclk) begin
        if (aresetn) begin
            check("flushing_vs_wren", 64'(bus.flushing), 64'(bus.cache_wren != '0));
            check("wdata_zero", 64'(bus.cache_wdata != '0), 64'(0));
            if (prev_stall) begin
                check("stall_addr", 64'(bus.cache_waddr), 64'(prev_addr));
                check("stall_wren", 64'(bus.cache_wren), 64'(prev_wren));
            end
            if (bus.cache_wren != '0 && bus.cache_wready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h wren %b, expected nothing (cycle %0d)",
                             bus.cache_waddr, bus.cache_wren, cyc);
                end else begin
                    it = sb.pop_front();
                    if (it.is_ack) begin
                        n_fail++;
                        $display("FAIL write_order: got write addr 0x%0h, expected flush_ack (cycle %0d)",
                                 bus.cache_waddr, cyc);
                    end else begin
                        check("write_addr", 64'(bus.cache_waddr), 64'(it.addr));
                        check("write_wren", 64'(bus.cache_wren), 64'(it.wren));
                    end
                end
            end
            if (bus.flush_ack) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: got flush_ack, expected nothing (cycle %0d)", cyc);
                end else begin
                    it = sb.pop_front();
                    if (!it.is_ack) begin
                        n_fail++;
                        $display("FAIL ack_order: got flush_ack, expected write addr 0x%0h (cycle %0d)",
                                 it.addr, cyc);
                    end
                end
            end
            prev_stall = (bus.cache_wren != '0) && !bus.cache_wready && !srst;
            prev_addr  = bus.cache_waddr;
            prev_wren  = bus.cache_wren;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference model: lines erased by a request, from the address rules.
    task automatic push_req(input bit rng, input logic [AW-1:0] st, input logic [AW-1:0] en,
                            input logic [WAYS-1:0] ways, output int count);
        int            s = 0;
        int            e;
        logic [AW-1:0] d;
        item_t         x;
        if (ways == '0) begin
            count = 0;
        end else if (!rng) begin
            count = DEPTH;
        end else begin
            s = int'((st / LINE_B) % DEPTH);
            e = int'((en / LINE_B) % DEPTH);
            d = en - st;
            if (d >= AW'(SPAN)) count = DEPTH;
            else count = ((e - s + DEPTH) % DEPTH) + 1;
        end
        for (int k = 0; k < count; k++) begin
            x.is_ack = 1'b0;
            x.addr   = AW'(((s + k) % DEPTH) * LINE_B);
            x.wren   = ways;
            sb.push_back(x);
        end
        x.is_ack = 1'b1;
        x.addr   = '0;
        x.wren   = '0;
        sb.push_back(x);
    endtask

    task automatic push_init();
        item_t x;
        for (int k = 0; k < DEPTH; k++) begin
            x.is_ack = 1'b0;
            x.addr   = AW'(k * LINE_B);
            x.wren   = '1;
            sb.push_back(x);
        end
    endtask

    task automatic wait_init(input int r0);
        int got = -1;
        for (int i = 0; i < 4000 && got < 0; i++) begin
            @(negedge aclk);
            if (bus.init_done) got = cyc;
        end
        if (got < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL init_timeout: got no init_done, expected it within 4000 cycles");
        end else begin
            check("init_done_cycle", 64'(got - r0), 64'(exp_done(r0, DEPTH) - r0));
        end
    endtask

    task automatic start_req(input bit rng, input logic [AW-1:0] st, input logic [AW-1:0] en,
                             input logic [WAYS-1:0] ways, output int t0, output int count);
        @(posedge aclk);
        #1;
        bus.flush_range = rng;
        bus.flush_start = st;
        bus.flush_end   = en;
        bus.flush_ways  = ways;
        bus.flush_req   = 1'b1;
        t0 = cyc;
        push_req(rng, st, en, ways, count);
        // Request fields are don't-care once accepted.
        @(posedge aclk);
        #1;
        bus.flush_range = 1'($urandom);
        bus.flush_start = $urandom;
        bus.flush_end   = $urandom;
        bus.flush_ways  = WAYS'($urandom);
    endtask

    task automatic finish_req(input int t0, input int count, input int hold);
        int got = -1;
        for (int i = 0; i < 5000 && got < 0; i++) begin
            @(negedge aclk);
            if (bus.flush_ack) got = cyc;
        end
        if (got < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: got no flush_ack, expected one within 5000 cycles");
        end else begin
            check("ack_latency", 64'(got - t0), 64'(exp_done(t0, count) - t0));
        end
        repeat (hold) @(posedge aclk);
        @(posedge aclk);
        #1;
        bus.flush_req = 1'b0;
    endtask

    task automatic do_req(input bit rng, input logic [AW-1:0] st, input logic [AW-1:0] en,
                          input logic [WAYS-1:0] ways, input int hold);
        int t0;
        int count;
        start_req(rng, st, en, ways, t0, count);
        finish_req(t0, count, hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wren"},      64'(bus.cache_wren), 64'(0));
        check({tag, "_flushing"},  64'(bus.flushing),   64'(0));
        check({tag, "_ack"},       64'(bus.flush_ack),  64'(0));
        check({tag, "_init_done"}, 64'(bus.init_done),  64'(0));
        check({tag, "_waddr"},     64'(bus.cache_waddr), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int            t0;
        int            count;
        int            r0;
        bit            rng;
        logic [AW-1:0] st;
        logic [AW-1:0] en;

        bus.flush_req    = 1'b0;
        bus.flush_range  = 1'b0;
        bus.flush_start  = '0;
        bus.flush_end    = '0;
        bus.flush_ways   = '0;
        bus.cache_wready = 1'b1;

        // Reset and post-reset sweep
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        check("reset_wdata", 64'(bus.cache_wdata != '0), 64'(0));
        push_init();
        aresetn = 1'b1;
        r0 = cyc;
        wait_init(r0);

        // Directed requests
        do_req(1'b0, 32'h0,         32'h0,         2'b01, 0);
        do_req(1'b1, 32'h120,       32'h15F,       2'b11, 0);
        do_req(1'b1, 32'h1FE0,      32'h0010,      2'b11, 0);
        do_req(1'b1, 32'h100,       32'h2100,      2'b10, 0);
        do_req(1'b1, 32'hFFFF_0120, 32'hFFFF_015F, 2'b01, 0);
        wmode = 1;
        do_req(1'b1, 32'h120,       32'h15F,       2'b11, 0);
        wmode = 0;
        do_req(1'b1, 32'h40,        32'h7F,        2'b01, 6);
        do_req(1'b1, 32'h40,        32'h7F,        2'b10, 0);
        do_req(1'b0, 32'h0,         32'h0,         2'b00, 0);
        do_req(1'b1, 32'h300,       32'h2300,      2'b00, 0);

        // Random requests under random backpressure
        wmode = 2;
        for (int n = 0; n < 25; n++) begin
            rng = ($urandom_range(4) != 0);
            st  = $urandom;
            if ($urandom_range(3) != 0) en = st + AW'($urandom_range(0, 40 * LINE_B));
            else en = $urandom;
            do_req(rng, st, en, WAYS'($urandom_range(0, 3)), $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a full flush
        start_req(1'b0, 32'h0, 32'h0, 2'b11, t0, count);
        repeat (20) @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("areset");
        sb.delete();
        push_init();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        r0 = cyc;
        wait_init(r0);
        // Request still high from before the reset: must not be served.
        repeat (3) @(posedge aclk);
        #1;
        bus.flush_req = 1'b0;

        // Synchronous reset in the middle of a range flush
        start_req(1'b1, 32'h0, 32'h1FFF, 2'b01, t0, count);
        repeat (10) @(posedge aclk);
        #1;
        srst = 1'b1;
        @(posedge aclk);
        #1;
        check_reset_outputs("srst");
        sb.delete();
        push_init();
        srst = 1'b0;
        r0 = cyc;
        bus.flush_req = 1'b0;
        wait_init(r0);

        wmode = 0;
        do_req(1'b1, 32'h1FC0, 32'h1FFF, 2'b11, 0);

        repeat (5) @(posedge aclk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/friscv_cache_invalidator.md
# friscv_cache_invalidator

Parametrised cache invalidation engine for the friscv instruction and data caches. It erases every line after reset, then serves FENCE.i-style full flushes and address-range invalidations. It writes one line index per accepted cycle across a selectable set of ways, and obeys backpressure from the cache RAM arbiter. It sits between the cache control FSM (request side) and the cache tag/data RAM write port (erase side).

## Interface
Parameters:
- NAME, "Cache-Invalidator", instance name for printing
- CACHE_BLOCK_W, 128, data payload bits per cache block; must be a power of two, ≥ 8
- CACHE_DEPTH, 512, lines per way; must be a power of two, ≥ 2
- NB_WAYS, 1, number of ways; 1..8
- AXI_ADDR_W, 32, byte address width; must satisfy AXI_ADDR_W ≥ OFFSET_W + INDEX_W

Derived constants:
- OFFSET_W = $clog2(CACHE_BLOCK_W/8)
- INDEX_W = $clog2(CACHE_DEPTH)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset; same effect as aresetn
- flush_req  in  1  level request; held high by requester until flush_ack
- flush_range  in  1  0 = full flush, 1 = range invalidate; sampled with flush_req
- flush_start  in  AXI_ADDR_W  range first byte address; sampled with flush_req
- flush_end  in  AXI_ADDR_W  range last byte address, inclusive; sampled with flush_req
- flush_ways  in  NB_WAYS  way mask to erase; sampled with flush_req
- flush_ack  out  1  one-cycle pulse when the request has completed
- flushing  out  1  high while erase writes are being issued
- init_done  out  1  high once the post-reset erase has completed; sticky
- cache_wren  out  NB_WAYS  per-way erase write enable
- cache_wready  in  1  RAM port accepts the write this cycle
- cache_waddr  out  AXI_ADDR_W  byte address of the line: index << OFFSET_W, other bits 0
- cache_wdata  out  CACHE_BLOCK_W  constant zero; valid bits are cleared by the same write

## Operation
- States: INIT, IDLE, FLUSH, ACK.
- Reset (async or srst): state INIT. Outputs flush_ack=0, flushing=0, init_done=0, cache_wren=0, cache_waddr=0. Internal: idx=0, remaining=CACHE_DEPTH, way mask all ones, req_armed=0.
- INIT: behaves as FLUSH over all CACHE_DEPTH lines and all ways, flushing=1.
  - On the last accepted write: init_done←1, go to IDLE. No flush_ack is issued.
  - flush_req is ignored during INIT.
- IDLE: idx counter held; cache_wren=0.
  - req_armed←1 whenever flush_req=0 is observed in IDLE.
  - If flush_req=1 and req_armed=1: capture mode, ways and range, then go to FLUSH.
  - flush_ways=0 goes directly to ACK with no writes.
- Full flush: idx starts at 0; count = CACHE_DEPTH.
- Range invalidate: s = flush_start[OFFSET_W+:INDEX_W], e = flush_end[OFFSET_W+:INDEX_W].
  - count = ((e − s) mod CACHE_DEPTH) + 1, computed in INDEX_W+1 bits.
  - e < s wraps from CACHE_DEPTH−1 back to 0.
  - Upper address bits are ignored; aliasing onto an index is intentional.
  - If flush_end − flush_start ≥ CACHE_DEPTH·CACHE_BLOCK_W/8 (unsigned), count = CACHE_DEPTH.
- FLUSH:
  - cache_wren = captured way mask; cache_waddr = idx << OFFSET_W.
  - On cache_wren≠0 && cache_wready: idx←idx+1 mod CACHE_DEPTH, remaining←remaining−1.
  - When the write with remaining==1 is accepted: cache_wren←0, flushing←0, flush_ack←1, go to ACK.
  - cache_wready=0 holds the address and wren stable; no write is lost.
- ACK: flush_ack=1 for exactly this one cycle. req_armed←0. Go to IDLE.
- A request must therefore drop for at least one cycle after ack before a new one is accepted.
- Every line in the selected range is written exactly once per request. No line outside the range and no unselected way is written.

## Timing
- Request accepted in IDLE at cycle T. First cache_wren at T+1.
- With cache_wready held high, writes occur on cycles T+1..T+count and flush_ack pulses at T+count+1.
- Every low cycle of cache_wready adds exactly one cycle.
- flushing is high exactly on the cycles where cache_wren≠0 (registered, same cycle).
- Post-reset init: first write on the first cycle after reset release. init_done rises the cycle after the CACHE_DEPTH-th accepted write.
- Reset mid-FLUSH: outputs return to their reset values on the next edge (async: immediately). An INIT sweep then restarts from index 0. Any outstanding request gets no ack and must be re-issued.
- flush_start, flush_end, flush_ways and flush_range may change after acceptance without effect.

## Test plan
- Reset, cache_wready=1, DEPTH=512, NB_WAYS=2 -> 512 writes, wren=2'b11, addresses 0x000..0x1FF0 step 0x10; init_done high at cycle 513; no flush_ack.
- Full flush request after init, ways=2'b01 -> 512 writes on way 0 only; ack pulse 513 cycles after acceptance; flushing high for 512 cycles.
- Range start=0x120, end=0x15F -> lines 0x12..0x15, four writes at 0x120, 0x130, 0x140, 0x150, then ack.
- Wrap range start=0x1FE0, end=0x0010 -> writes at 0x1FE0, 0x1FF0, 0x0000, 0x0010.
- Range end − start ≥ 0x2000 -> count = 512.
- Toggle cache_wready 0/1 every cycle during a 4-line range -> address held stable while low; exactly 4 accepted writes; ack at T+9.
- flush_req held high through ack -> exactly one flush. Drop for one cycle and reassert -> second flush. Assert aresetn low mid-flush -> outputs zero, INIT sweep restarts from index 0, no ack.
